fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO among several write-domain requesters. It sits in the write clock domain in front of the write pointer manager. It drives that block's req_write and the write data from the granted requester, and uses flag_full to stall. Grants are held for bounded bursts so that no requester is starved. A sticky error flag latches any overflow the pointer manager reports.

## Interface
- NUM_REQ, 4, number of requesters, 2..8
- DATA_WIDTH, 8, write data width
- MAX_BURST, 4, maximum accepted beats per grant, 1..15
- clk_write  in  1  write-domain clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_in  in  NUM_REQ  per-requester write request, level, held until beat accepted
- data_in  in  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
- flag_full  in  1  FIFO full, from write pointer manager
- flag_of  in  1  FIFO overflow pulse, from write pointer manager
- grant_out  out  NUM_REQ  registered one-hot grant, all-zero when idle
- ack_out  out  NUM_REQ  combinational, one-hot beat-accepted strobe
- req_write  out  1  write request to pointer manager
- data_write  out  DATA_WIDTH  data of granted requester
- err_overflow  out  1  sticky overflow indication

## Operation
- States:
  - IDLE: grant_out = 0.
  - OWN: exactly one grant bit set; owner index held in a register.
- Accept condition for owner o in a cycle: grant_out[o] & req_in[o] & ~flag_full.
- When the accept condition holds:
  - ack_out[o] = 1 and req_write = 1.
  - data_write = data_in slice o.
  - Otherwise ack_out = 0 and req_write = 0.
- data_write = slice of the current owner whenever in OWN. It is 0 in IDLE.
- beat_cnt (4 bits) counts accepts in the current grant. It is cleared on every new grant.
- Release at an edge while in OWN, on either condition:
  - req_in[o] = 0, or
  - an accept occurs with beat_cnt == MAX_BURST-1.
- Next-owner selection is used both on release and in IDLE:
  - Search req_in from last_owner+1 upward, wrapping modulo NUM_REQ.
  - The first set bit wins.
  - The previous owner is checked last, so it is re-granted only if it is the sole requester.
- Transitions:
  - On release, if any req_in bit is set, move directly to OWN with the new owner at the same edge, with no idle cycle. Otherwise go to IDLE.
  - IDLE to OWN when any req_in bit is set.
- last_owner is updated whenever a grant is issued.
- flag_full = 1 stalls the transfer:
  - no accept, beat_cnt holds, no release on the burst limit;
  - release by req_in[o] dropping still applies.
- err_overflow is set on any cycle with flag_of = 1 and stays set until reset.
- Requesters may change data_in only after seeing ack_out.

## Timing
- Reset values:
  - grant_out = 0, ack_out = 0, req_write = 0, data_write = 0, err_overflow = 0;
  - state IDLE, beat_cnt = 0, last_owner = NUM_REQ-1, so requester 0 has first priority.
- Reset takes precedence over all other events, including mid-burst. Any in-flight grant is dropped at that edge.
- Request-to-grant latency: req_in sampled at edge t gives grant_out at t+1. The first accept is possible in the cycle after edge t.
- Accept-to-write latency: 0. req_write is combinational from the registered grant, req_in and flag_full.
- Sustained throughput with the FIFO not full: 1 beat per cycle, including across grant handover.
- Burst of MAX_BURST from one requester uses MAX_BURST consecutive accept cycles. The grant moves at the edge ending the last beat.
- Simultaneous events:
  - If flag_full rises in a cycle, that cycle has no accept.
  - flag_of and reset in the same cycle: reset wins, so err_overflow = 0.

## Test plan
- Reset:
  - Hold reset 2 cycles with all req_in = 1.
  - Required: all outputs 0 during reset; grant_out = 0001 one cycle after reset release.
- Single requester, MAX_BURST = 4:
  - req_in = 0100 held.
  - Required: 4 consecutive ack_out[2]/req_write pulses, then re-grant to 2 with no gap, since it is the sole requester.
- Round robin:
  - req_in = 1011 held, MAX_BURST = 4.
  - Required: grant order 0, 1, 3, 0, each for 4 beats; data_write matches each slice; no idle cycles between grants.
- Full stall:
  - flag_full = 1 for 3 cycles mid-burst after beat 2.
  - Required: no req_write during the stall, beat_cnt holds, remaining 2 beats complete after flag_full falls, then handover.
- Early release and overflow:
  - Owner drops req_in after 1 beat; pulse flag_of once.
  - Required: the grant moves to the next requester at that edge; err_overflow rises the next cycle and stays 1 until reset.
- Reset mid-burst:
  - Assert reset during beat 3 of a grant to requester 1.
  - Required: grant_out = 0 the next cycle; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between the write-domain requesters and the FIFO write
// arbiter, including the pointer-manager status flags it observes.
//   master : requester/pointer-manager side (drives req_in, data_in, flags)
//   slave  : arbiter side (drives grant/ack, req_write, data_write, error)
interface fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [NUM_REQ-1:0]            req_in;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_in;
  logic                          flag_full;
  logic                          flag_of;
  logic [NUM_REQ-1:0]            grant_out;
  logic [NUM_REQ-1:0]            ack_out;
  logic                          req_write;
  logic [DATA_WIDTH-1:0]         data_write;
  logic                          err_overflow;

  modport master (
    output req_in, data_in, flag_full, flag_of,
    input  grant_out, ack_out, req_write, data_write, err_overflow
  );

  modport slave (
    input  req_in, data_in, flag_full, flag_of,
    output grant_out, ack_out, req_write, data_write, err_overflow
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the asynchronous FIFO write port among NUM_REQ
// write-domain requesters. Grants last at most MAX_BURST accepted beats,
// stall on flag_full, and hand over with no idle cycle. Overflow pulses from
// the pointer manager are latched into a sticky error flag.
// Ports:
//   clk_write : write-domain clock (rising edge)
//   reset     : synchronous, active-high
//   bus       : slave side of fifo_write_arbiter_if
//               in : req_in, data_in, flag_full, flag_of
//               out: grant_out (registered one-hot), ack_out (comb strobe),
//                    req_write, data_write, err_overflow (sticky)
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                clk_write,
  input  logic                reset,
  fifo_write_arbiter_if.slave bus
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_owner, w_owner_nxt;
  logic [IW-1:0]      r_last_owner, w_last_nxt;
  logic [3:0]         r_beat_cnt, w_beat_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_err;

  logic               w_accept;
  logic               w_release;
  logic               w_found;
  logic [IW-1:0]      w_pick;

  // Rotating search starting just after the last owner; the last owner
  // itself is visited last so it only wins when nobody else is requesting.
  function automatic logic [IW:0] pick_next(input logic [NUM_REQ-1:0] req,
                                            input logic [IW-1:0]      last);
    logic          found;
    logic [IW-1:0] sel;
    int unsigned   idx;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
    return {found, sel};
  endfunction

  always_comb begin
    {w_found, w_pick} = pick_next(bus.req_in, r_last_owner);
  end

  assign w_accept  = (r_state == S_OWN) && bus.req_in[r_owner] && !bus.flag_full;
  // Burst-limit release only counts on an actual accept, so a full stall
  // never ends a grant early; a dropped request always does.
  assign w_release = (r_state == S_OWN) &&
                     (!bus.req_in[r_owner] ||
                      (w_accept && (r_beat_cnt == 4'(MAX_BURST - 1))));

  // State register
  always_ff @(posedge clk_write) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= IW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_grant      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_grant      <= w_grant_nxt;
      r_err        <= r_err | bus.flag_of;
    end
  end

  // Next-state logic: release and idle share the same selection, so a
  // handover goes straight to the new owner at the releasing edge.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_beat_nxt  = r_beat_cnt;
    w_grant_nxt = r_grant;
    if ((r_state == S_IDLE) || w_release) begin
      w_beat_nxt = '0;
      if (w_found) begin
        w_state_nxt = S_OWN;
        w_owner_nxt = w_pick;
        w_last_nxt  = w_pick;
        w_grant_nxt = NUM_REQ'(1) << w_pick;
      end else begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    end else if (w_accept) begin
      w_beat_nxt = r_beat_cnt + 4'd1;
    end
  end

  // Output logic
  always_comb begin
    bus.grant_out    = r_grant;
    bus.ack_out      = '0;
    bus.req_write    = 1'b0;
    bus.data_write   = '0;
    bus.err_overflow = r_err;
    if (r_state == S_OWN) begin
      bus.data_write = bus.data_in[r_owner*DATA_WIDTH +: DATA_WIDTH];
    end
    if (w_accept) begin
      bus.ack_out[r_owner] = 1'b1;
      bus.req_write        = 1'b1;
    end
  end

endmodule
